axis_frame_arbiter: RTL

//  Shares one AXI-Stream slave input (video sink) between NUM_SRC AXI-Stream sources.

---
 rtl/axis_frame_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: multiplexes NUM_SRC AXI-Stream video sources
// onto one sink, switching sources only on start-of-frame after LINES_PER_FRAME lines.
module axis_frame_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_SRC         = 2,
    parameter int unsigned LINES_PER_FRAME = 480
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            arb_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    input  logic [NUM_SRC-1:0]              s_axis_tuser,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    output logic [$clog2(NUM_SRC)-1:0]      grant_idx,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            sof_err,
    output logic                            drop
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned LCW   = $clog2(LINES_PER_FRAME + 1);
    localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES_PER_FRAME - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]            state, state_nxt;
    logic [SRC_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [SRC_W-1:0]      grant_nxt;
    logic [LCW-1:0]        line_cnt, line_cnt_nxt, line_base;
    logic                  first_beat, first_beat_nxt;
    logic                  frame_done_nxt, sof_err_nxt, drop_nxt;
    logic [NUM_SRC-1:0]    req, flush;
    logic                  found, accept;
    logic [SRC_W-1:0]      winner, scan_idx;
    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

    assign req   = s_axis_tvalid & s_axis_tuser;
    assign flush = s_axis_tvalid & ~s_axis_tuser;
    assign busy  = (state == STREAM);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // State register and registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            line_cnt   <= '0;
            first_beat <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            grant_idx  <= grant_nxt;
            line_cnt   <= line_cnt_nxt;
            first_beat <= first_beat_nxt;
            frame_done <= frame_done_nxt;
            sof_err    <= sof_err_nxt;
            drop       <= drop_nxt;
        end
    end

    // Next-state, arbitration and stream mux
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        grant_nxt      = grant_idx;
        line_cnt_nxt   = line_cnt;
        first_beat_nxt = first_beat;
        frame_done_nxt = 1'b0;
        sof_err_nxt    = 1'b0;
        drop_nxt       = 1'b0;
        s_axis_tready  = '0;
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        found          = 1'b0;
        winner         = '0;
        scan_idx       = '0;
        accept         = 1'b0;
        line_base      = line_cnt;

        case (state)
            IDLE: begin
                // SOF beats are held for the winner; everything else is flushed
                s_axis_tready = flush;
                drop_nxt      = |flush;
                if (arb_en) begin
                    for (int unsigned k = 0; k < NUM_SRC; k++) begin
                        scan_idx = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
                        if (!found && req[scan_idx]) begin
                            found  = 1'b1;
                            winner = scan_idx;
                        end
                    end
                end
                if (found) begin
                    grant_nxt      = winner;
                    line_cnt_nxt   = '0;
                    first_beat_nxt = 1'b1;
                    state_nxt      = STREAM;
                end
            end
            default: begin
                m_axis_tdata             = src_data[grant_idx];
                m_axis_tvalid            = s_axis_tvalid[grant_idx];
                m_axis_tlast             = s_axis_tlast[grant_idx];
                m_axis_tuser             = s_axis_tuser[grant_idx];
                s_axis_tready[grant_idx] = m_axis_tready;
                accept = s_axis_tvalid[grant_idx] & m_axis_tready;
                if (accept) begin
                    first_beat_nxt = 1'b0;
                    // A stray SOF restarts the line count; its own tlast counts as line one
                    if (s_axis_tuser[grant_idx] && !first_beat) begin
                        sof_err_nxt  = 1'b1;
                        line_base    = '0;
                        line_cnt_nxt = '0;
                    end
                    if (s_axis_tlast[grant_idx]) begin
                        if (line_base == LAST_LINE) begin
                            line_cnt_nxt   = '0;
                            rr_ptr_nxt     = SRC_W'((32'(grant_idx) + 32'd1) % NUM_SRC);
                            frame_done_nxt = 1'b1;
                            state_nxt      = IDLE;
                        end else begin
                            line_cnt_nxt = line_base + LCW'(1);
                        end
                    end
                end
            end
        endcase

        if (rst) begin
            s_axis_tready = '0;
            m_axis_tdata  = '0;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
            m_axis_tuser  = 1'b0;
        end
    end

endmodule
